// File: rtl/multiplexed_seven_segment_driver.sv
// Time-multiplexed seven-segment scanner with frame-synchronous value updates and blanking.
// Latency: outputs are registered and match the prescaler/index state after each edge; new values appear at the next frame.
// Backpressure: none; Load is always accepted, and the last Load before a frame boundary wins.
module multiplexed_seven_segment_driver #(
    parameter int NUM_DIGITS         = 4,
    parameter int REFRESH_DIV        = 100000,
    parameter int BLANK_CYCLES       = 1000,
    parameter int ACTIVE_LOW         = 1,
    parameter int LEADING_ZERO_BLANK = 1
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic [4*NUM_DIGITS-1:0]   Value,
    input  logic [NUM_DIGITS-1:0]     DigitEnable,
    input  logic [NUM_DIGITS-1:0]     DecimalPoint,
    input  logic                      Load,
    output logic [NUM_DIGITS-1:0]     Anode,
    output logic [6:0]                Segments,
    output logic                      Dp,
    output logic                      FrameStart
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PW-1:0] P_LAST     = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] I_LAST     = IW'(NUM_DIGITS - 1);
    localparam logic [PW-1:0] BLANK_LAST = PW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic          POL        = (ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] AN_OFF = {NUM_DIGITS{POL}};
    localparam logic [6:0]    SEG_OFF    = {7{POL}};
    localparam logic [6:0]    SEG_INV    = {7{!POL}};

    logic [PW-1:0]           p, p_nxt;
    logic [IW-1:0]           idx, idx_nxt;
    logic                    wrap, frame_edge;
    logic [4*NUM_DIGITS-1:0] pend_val, act_val, act_val_nxt;
    logic [NUM_DIGITS-1:0]   pend_en, act_en, act_en_nxt;
    logic [NUM_DIGITS-1:0]   pend_dp, act_dp, act_dp_nxt;
    logic [3:0]              nib;
    logic                    en_bit, dp_bit, lz_zero, blank_slot, lit;
    logic [NUM_DIGITS-1:0]   onehot, an_nxt;
    logic [6:0]              seg_nxt;
    logic                    dp_nxt;

    // Active-low g..a codes; active-high polarity is handled by XOR at the output.
    function automatic logic [6:0] hex_to_seg_n(input logic [3:0] h);
        case (h)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    always_comb begin
        wrap       = (p == P_LAST);
        frame_edge = wrap && (idx == I_LAST);
        p_nxt      = wrap ? '0 : p + 1'b1;
        idx_nxt    = wrap ? ((idx == I_LAST) ? '0 : idx + 1'b1) : idx;

        // A Load on the boundary edge bypasses pending so the new frame shows it directly.
        act_val_nxt = act_val;
        act_en_nxt  = act_en;
        act_dp_nxt  = act_dp;
        if (frame_edge) begin
            act_val_nxt = Load ? Value        : pend_val;
            act_en_nxt  = Load ? DigitEnable  : pend_en;
            act_dp_nxt  = Load ? DecimalPoint : pend_dp;
        end
    end

    always_comb begin
        nib     = '0;
        en_bit  = 1'b0;
        dp_bit  = 1'b0;
        lz_zero = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_nxt == IW'(k)) begin
                nib    = act_val_nxt[4*k +: 4];
                en_bit = act_en_nxt[k];
                dp_bit = act_dp_nxt[k];
            end
            if (k >= int'(idx_nxt) && act_val_nxt[4*k +: 4] != 4'd0)
                lz_zero = 1'b0;
        end

        blank_slot = (BLANK_CYCLES > 0) && (p_nxt <= BLANK_LAST);
        lit        = !blank_slot && en_bit &&
                     !((LEADING_ZERO_BLANK != 0) && (idx_nxt != '0) && lz_zero);
        onehot     = NUM_DIGITS'(1) << idx_nxt;
        an_nxt     = lit ? (onehot ^ AN_OFF) : AN_OFF;
        seg_nxt    = lit ? (hex_to_seg_n(nib) ^ SEG_INV) : SEG_OFF;
        dp_nxt     = (lit && dp_bit) ^ POL;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            p          <= '0;
            idx        <= '0;
            pend_val   <= '0;
            pend_en    <= '0;
            pend_dp    <= '0;
            act_val    <= '0;
            act_en     <= '0;
            act_dp     <= '0;
            Anode      <= AN_OFF;
            Segments   <= SEG_OFF;
            Dp         <= POL;
            FrameStart <= 1'b0;
        end else begin
            p          <= p_nxt;
            idx        <= idx_nxt;
            if (Load) begin
                pend_val <= Value;
                pend_en  <= DigitEnable;
                pend_dp  <= DecimalPoint;
            end
            act_val    <= act_val_nxt;
            act_en     <= act_en_nxt;
            act_dp     <= act_dp_nxt;
            Anode      <= an_nxt;
            Segments   <= seg_nxt;
            Dp         <= dp_nxt;
            FrameStart <= frame_edge;
        end
    end

endmodule

// File: tb/tb_multiplexed_seven_segment_driver.sv
// Directed table-driven bench: 4 digits, 4-cycle slots with 1 blank cycle, so each frame is 16 cycles.
module tb_multiplexed_seven_segment_driver;

    typedef struct packed {
        logic [15:0] val;
        logic [3:0]  en;
        logic [3:0]  dp;
        logic [15:0] an;    // expected anode per slot, {slot3,slot2,slot1,slot0}
        logic [27:0] seg;   // expected segments per slot, {slot3..slot0}
        logic [3:0]  dpo;   // expected Dp per slot
    } vec_t;

    localparam int NV = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value;
    logic [3:0]  digit_en;
    logic [3:0]  dec_pt;
    logic        load;
    logic [3:0]  anode;
    logic [6:0]  segments;
    logic        dp;
    logic        frame_start;

    int n_cmp  = 0;
    int n_fail = 0;
    vec_t tbl [NV];

    multiplexed_seven_segment_driver #(
        .NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(1),
        .ACTIVE_LOW(1), .LEADING_ZERO_BLANK(1)
    ) dut (
        .Clock(clk), .Reset(rst), .Value(value), .DigitEnable(digit_en),
        .DecimalPoint(dec_pt), .Load(load), .Anode(anode), .Segments(segments),
        .Dp(dp), .FrameStart(frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int cyc, input logic [12:0] act, input logic [12:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s c=%0d: got {fs,dp,an,seg}=%b_%b_%b_%b required %b_%b_%b_%b",
                     name, cyc, act[12], act[11], act[10:7], act[6:0],
                     exp[12], exp[11], exp[10:7], exp[6:0]);
        end
    endtask

    task automatic drive_idle();
        load     = 1'b0;
        value    = 16'hBEEF;
        digit_en = 4'b0110;
        dec_pt   = 4'b1010;
    endtask

    task automatic drive_load(input vec_t v);
        load     = 1'b1;
        value    = v.val;
        digit_en = v.en;
        dec_pt   = v.dp;
    endtask

    // Entered and left at the negedge right after a FrameStart edge (cycle 0 of a frame).
    task automatic check_frame(input string name, input vec_t e,
                               input int la, input vec_t a, input int lb, input vec_t b);
        logic [12:0] exp;
        int slot;
        for (int c = 0; c < 16; c++) begin
            slot = c / 4;
            if (c % 4 == 0)
                exp = {(c == 0), 1'b1, 4'hF, 7'h7F};
            else
                exp = {1'b0, e.dpo[slot], e.an[slot*4 +: 4], e.seg[slot*7 +: 7]};
            chk(name, c, {frame_start, dp, anode, segments}, exp);
            if (c == la)      drive_load(a);
            else if (c == lb) drive_load(b);
            else              drive_idle();
            @(negedge clk);
        end
    endtask

    // Reset, then load in the first cycle after release; the first frame is blank and ends at edge 16.
    task automatic reset_and_start(input string name, input vec_t v);
        drive_idle();
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk({name, "_rst"}, k, {frame_start, dp, anode, segments}, {1'b0, 1'b1, 4'hF, 7'h7F});
        end
        rst = 1'b0;
        drive_load(v);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 1) drive_idle();
            chk({name, "_first"}, k, {frame_start, dp, anode, segments}, {(k == 16), 1'b1, 4'hF, 7'h7F});
        end
    endtask

    initial begin
        tbl[0] = '{val:16'h12AF, en:4'hF, dp:4'h0, an:16'h7BDE,
                   seg:{7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110}, dpo:4'hF};
        tbl[1] = '{val:16'h0050, en:4'hF, dp:4'h0, an:16'hFFDE,
                   seg:{7'b1111111, 7'b1111111, 7'b0010010, 7'b1000000}, dpo:4'hF};
        tbl[2] = '{val:16'h1234, en:4'b1011, dp:4'b0001, an:16'h7FDE,
                   seg:{7'b1111001, 7'b1111111, 7'b0110000, 7'b0011001}, dpo:4'b1110};
        tbl[3] = '{val:16'h9999, en:4'hF, dp:4'h0, an:16'h7BDE,
                   seg:{7'b0010000, 7'b0010000, 7'b0010000, 7'b0010000}, dpo:4'hF};
        tbl[4] = '{val:16'h0000, en:4'hF, dp:4'hF, an:16'hFFFE,
                   seg:{7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000}, dpo:4'b1110};
        tbl[5] = '{val:16'h0C0E, en:4'hF, dp:4'b1000, an:16'hFBDE,
                   seg:{7'b1111111, 7'b1000110, 7'b1000000, 7'b0000110}, dpo:4'hF};
        tbl[6] = '{val:16'h8B6D, en:4'hF, dp:4'b0110, an:16'h7BDE,
                   seg:{7'b0000000, 7'b0000011, 7'b0000010, 7'b0100001}, dpo:4'b1001};
        tbl[7] = '{val:16'h3570, en:4'hF, dp:4'h0, an:16'h7BDE,
                   seg:{7'b0110000, 7'b0010010, 7'b1111000, 7'b1000000}, dpo:4'hF};
        tbl[8] = '{val:16'h1111, en:4'h0, dp:4'hF, an:16'hFFFF,
                   seg:{7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111}, dpo:4'hF};
        tbl[9] = '{val:16'h5000, en:4'b0111, dp:4'h0, an:16'hFBDE,
                   seg:{7'b1111111, 7'b1000000, 7'b1000000, 7'b1000000}, dpo:4'hF};

        rst = 1'b1;
        drive_idle();

        reset_and_start("startup", tbl[0]);

        // Each frame shows the previous vector while the next one is loaded mid-frame.
        for (int i = 1; i < NV; i++)
            check_frame("table", tbl[i-1], 3, tbl[i], -1, tbl[i]);

        check_frame("bound_load", tbl[NV-1], 15, tbl[0], -1, tbl[0]);
        check_frame("repeat_load", tbl[0], 2, tbl[3], 7, tbl[1]);
        check_frame("last_wins", tbl[1], 5, tbl[3], -1, tbl[3]);
        check_frame("mid_9999", tbl[3], -1, tbl[0], -1, tbl[0]);

        // Reset during the digit 2 slot (cycle 9 of the frame).
        for (int c = 0; c < 9; c++) @(negedge clk);
        reset_and_start("midreset", tbl[4]);
        check_frame("after_reset", tbl[4], -1, tbl[0], -1, tbl[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
